icache: RTL and testbench
=========================

# icache

Direct-mapped, read-only instruction cache sitting between the pipeline's fetch stage and the memory controller. It answers fetch requests (imemREN/imemaddr) with ihit/imemload, and on a miss issues a single-word read (iREN/iaddr) to the memory controller and waits for iwait to drop. Holds 16 one-word frames, with a valid bit and a 26-bit tag per frame. Also keeps hit/miss counters for performance checks.

## Interface
- Parameters:
- NFRAMES, 16, number of frames; must be a power of two; index width is log2(NFRAMES) = 4.
- Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- imemREN  in  1  fetch request from the datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] are ignored.
- ihit  out  1  fetch satisfied this cycle; imemload is valid.
- imemload  out  32  instruction word.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  word-aligned read address to the memory controller.
- iwait  in  1  memory controller busy; fill data is valid in any cycle where iREN=1 and iwait=0.
- iload  in  32  fill data from the memory controller.
- hit_count  out  32  number of completed hits, saturating.
- miss_count  out  32  number of misses started, saturating.

## Operation
- Address split: tag = imemaddr[31:6]; index = imemaddr[5:2]; offset = imemaddr[1:0], which is ignored.
- Lookup is combinational. A hit requires imemREN=1, state IDLE, valid[index]=1 and tag[index]=tag.
- On a hit: ihit=1 and imemload=data[index].
- On a non-hit, imemload is 0.
- FSM, two states:
  - IDLE: on imemREN=1 with a lookup miss, latch miss_addr = {imemaddr[31:2],2'b00}, increment miss_count, and go to FETCH.
  - FETCH: iREN=1, iaddr=miss_addr, ihit=0. In a cycle where iwait=0, on the next edge:
    - write data[idx(miss_addr)]=iload;
    - write tag[idx(miss_addr)]=tag(miss_addr);
    - set valid[idx(miss_addr)]=1;
    - return to IDLE.
- In IDLE: iREN=0 and iaddr=0.
- The fill always completes once started, even if imemREN drops or imemaddr changes during FETCH. It uses the latched miss_addr.
- After returning to IDLE, a changed imemaddr simply re-looks-up and may miss again.
- A fill replaces whatever frame occupies that index (direct-mapped eviction).
- hit_count increments on each cycle where ihit=1.
- Both counters saturate at 32'hFFFFFFFF.
- The cache is never invalidated except by reset. There is no write path: instruction memory is read-only.

## Timing
- Reset values:
  - state IDLE; all valid=0; miss_addr=0; hit_count=0; miss_count=0.
  - ihit=0, imemload=0, iREN=0, iaddr=0.
  - Tag and data arrays need not be reset.
- Reset is asynchronous and takes effect mid-FETCH: iREN falls with nRST, and the fill is abandoned with no frame written.
- Hit latency: 0 cycles (combinational, same cycle as the request).
- Miss latency: a request missing in cycle 0 drives iREN from cycle 1. With iwait low in cycle k ≥ 1, the frame is written at the end of cycle k and ihit=1 in cycle k+1.
  - Minimum miss-to-hit latency is 2 cycles.
- iaddr and iREN are registered-state outputs: they depend only on state and miss_addr.
- ihit depends combinationally on imemaddr, imemREN and the array contents.

## Structure
- Add to cpu_types_pkg:
  - ITAG_W=26, IIDX_W=4;
  - icache_frame_t, a packed struct with fields valid, tag[25:0] and data (word_t);
  - an icache_state_t enum {IDLE, FETCH}.
- Use word_t for every 32-bit port.
- No sub-module: the 16-entry frame array is an array of icache_frame_t inside this block.

## Test plan
- Cold miss: reset, imemREN=1, imemaddr=0x00000040; iwait held 1 for 3 cycles, then 0 with iload=0xDEADBEEF.
  - Required: iREN=1 and iaddr=0x40 for 4 cycles.
  - Next cycle: ihit=1, imemload=0xDEADBEEF, miss_count=1.
- Hit: repeat address 0x42 (offset ignored) -> ihit=1 in the same cycle, imemload=0xDEADBEEF, hit_count increments by 1.
- Conflict eviction:
  - Fill 0x00000040, then request 0x00000080 (same index 0, different tag) -> miss, fill 0x11111111.
  - Then 0x40 misses again; miss_count=3.
- Address change mid-FETCH: miss on 0x10, then switch imemaddr to 0x20 while iwait=1.
  - Required: iaddr stays 0x10; frame 4 is filled.
  - After return to IDLE, 0x20 misses and issues iaddr=0x20.
- Reset mid-FETCH: assert nRST=0 while iREN=1.
  - Required: iREN=0 immediately.
  - After release, a request to the same address misses (valid was cleared).
- imemREN=0 with a matching valid frame -> ihit=0, imemload=0, counters unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the instruction cache frame and FSM state
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int ITAG_W = 26;
  localparam int IIDX_W = 4;
  typedef logic [WORD_W-1:0] word_t;
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;
  typedef enum logic {IDLE, FETCH} icache_state_t;
endpackage

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with single-word fills and hit/miss counters
module icache
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);
  icache_frame_t     frames_q [NFRAMES];
  icache_frame_t     cur;
  icache_state_t     state_q;
  word_t             miss_addr_q, hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic [IIDX_W-1:0] idx, fill_idx;
  logic [ITAG_W-1:0] tag;
  logic              miss, unused_offset;
  assign tag           = imemaddr[31:32-ITAG_W];
  assign idx           = imemaddr[IIDX_W+1:2];
  assign fill_idx      = miss_addr_q[IIDX_W+1:2];
  assign unused_offset = ^imemaddr[1:0];
  assign cur           = frames_q[idx];
  assign ihit          = imemREN && state_q == IDLE && cur.valid && cur.tag == tag;
  assign miss          = imemREN && state_q == IDLE && !ihit;
  assign imemload      = ihit ? cur.data : '0;
  assign iREN          = state_q == FETCH;
  assign iaddr         = iREN ? miss_addr_q : '0;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
  // saturating next-count for hits and started misses
  always_comb begin
    hit_count_d  = (ihit && hit_count_q != '1) ? hit_count_q + 32'd1 : hit_count_q;
    miss_count_d = (miss && miss_count_q != '1) ? miss_count_q + 32'd1 : miss_count_q;
  end
  // miss FSM: latch the word address on a miss, hold it until the controller delivers
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else if (state_q == IDLE) begin
      if (miss) begin
        miss_addr_q <= {imemaddr[31:2], 2'b00};
        state_q     <= FETCH;
      end
    end else if (!iwait) begin
      state_q <= IDLE;
    end
  // frame array: cleared on reset, one frame replaced when fill data arrives
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST)
      for (int i = 0; i < NFRAMES; i++) frames_q[i] <= '0;
    else if (iREN && !iwait)
      frames_q[fill_idx] <= '{valid: 1'b1, tag: miss_addr_q[31:32-ITAG_W], data: iload};
  // performance counters
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed, table-driven and randomized checks of the instruction cache
module tb_icache;
  import cpu_types_pkg::*;
  logic  CLK = 0, nRST = 0, imemREN = 0, iwait = 1;
  word_t imemaddr = '0, iload = '0;
  logic  ihit, iREN;
  word_t imemload, iaddr, hit_count, miss_count;
  int    checks = 0, errors = 0;
  typedef struct {
    word_t a;
    word_t d;
    int    nw;
  } vec_t;
  vec_t  tbl [4];
  word_t res [word_t];
  word_t vic [$];
  bit    fetching;
  word_t maddr, mh, mm, wa;
  logic  eh;
  always #5 CLK = ~CLK;
  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic smp();
    @(negedge CLK);
  endtask
  task automatic miss_fill(input word_t a, input word_t d, input int nw);
    cyc();
    imemREN = 1; imemaddr = a; iwait = 1; iload = '0;
    smp();
    chk("miss_lookup", ihit, 0);
    chk("miss_idle_iren", iREN, 0);
    for (int k = 1; k <= nw + 1; k++) begin
      cyc();
      iwait = (k <= nw);
      iload = (k <= nw) ? 32'h0 : d;
      smp();
      chk("fetch_iren", iREN, 1);
      chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
    end
    cyc();
    iwait = 1;
    smp();
    chk("fill_hit", ihit, 1);
    chk("fill_data", imemload, d);
  endtask
  initial begin
    tbl[0] = '{32'h0000_004C, 32'hCAFE_F00D, 0};
    tbl[1] = '{32'h1000_0008, 32'h0BAD_F00D, 2};
    tbl[2] = '{32'hFFFF_FFFF, 32'h1234_5678, 5};
    tbl[3] = '{32'h0000_0004, 32'h8765_4321, 1};
    cyc(); cyc();
    smp();
    chk("rst_ihit", ihit, 0);
    chk("rst_load", imemload, 0);
    chk("rst_iren", iREN, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    cyc();
    nRST = 1;
    miss_fill(32'h40, 32'hDEAD_BEEF, 3);
    chk("cold_misses", miss_count, 1);
    chk("cold_hits", hit_count, 0);
    cyc(); imemaddr = 32'h42; smp();
    chk("hit_ihit", ihit, 1);
    chk("hit_load", imemload, 32'hDEAD_BEEF);
    chk("hit_count1", hit_count, 1);
    cyc(); imemREN = 0; smp();
    chk("noren_ihit", ihit, 0);
    chk("noren_load", imemload, 0);
    chk("hit_count2", hit_count, 2);
    cyc(); smp();
    chk("noren_hits", hit_count, 2);
    chk("noren_misses", miss_count, 1);
    miss_fill(32'h80, 32'h1111_1111, 1);
    chk("evict_misses", miss_count, 2);
    miss_fill(32'h40, 32'hDEAD_BEEF, 0);
    chk("refill_misses", miss_count, 3);
    foreach (tbl[i]) miss_fill(tbl[i].a, tbl[i].d, tbl[i].nw);
    foreach (tbl[i]) begin
      cyc(); imemaddr = tbl[i].a; smp();
      chk("tbl_hit", ihit, 1);
      chk("tbl_data", imemload, tbl[i].d);
    end
    cyc(); imemREN = 1; imemaddr = 32'h10; iwait = 1; smp();
    chk("chg_miss", ihit, 0);
    cyc(); imemaddr = 32'h20; smp();
    chk("chg_iren", iREN, 1);
    chk("chg_iaddr1", iaddr, 32'h10);
    cyc(); imemREN = 0; smp();
    chk("chg_iaddr2", iaddr, 32'h10);
    cyc(); iwait = 0; iload = 32'hA5A5_A5A5; smp();
    chk("chg_iaddr3", iaddr, 32'h10);
    cyc(); iwait = 1; imemREN = 1; imemaddr = 32'h20; smp();
    chk("chg_idle", iREN, 0);
    chk("chg_miss20", ihit, 0);
    cyc(); smp();
    chk("chg_iren20", iREN, 1);
    chk("chg_iaddr20", iaddr, 32'h20);
    cyc(); iwait = 0; iload = 32'h5A5A_5A5A; smp();
    cyc(); iwait = 1; smp();
    chk("chg_hit20", ihit, 1);
    chk("chg_data20", imemload, 32'h5A5A_5A5A);
    cyc(); imemaddr = 32'h10; smp();
    chk("chg_hit10", ihit, 1);
    chk("chg_data10", imemload, 32'hA5A5_A5A5);
    cyc(); imemaddr = 32'h100; smp();
    chk("rstf_miss", ihit, 0);
    cyc(); imemREN = 0; smp();
    chk("rstf_iren", iREN, 1);
    #1 nRST = 0;
    #1;
    chk("rstf_iren_drop", iREN, 0);
    chk("rstf_iaddr", iaddr, 0);
    chk("rstf_misses", miss_count, 0);
    chk("rstf_hits", hit_count, 0);
    cyc(); cyc();
    nRST = 1;
    miss_fill(32'h100, 32'h0F0F_0F0F, 0);
    miss_fill(32'h40, 32'hDEAD_BEEF, 0);
    chk("rstf_refills", miss_count, 2);
    cyc(); imemREN = 0; nRST = 0;
    cyc(); nRST = 1;
    res.delete(); fetching = 0; maddr = '0; mh = '0; mm = '0;
    for (int n = 0; n < 1500; n++) begin
      cyc();
      imemREN = $urandom_range(0, 3) != 0;
      imemaddr = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) imemaddr[31] = 1'b1;
      iwait = $urandom_range(0, 1);
      iload = $urandom;
      smp();
      wa = {imemaddr[31:2], 2'b00};
      eh = imemREN && !fetching && res.exists(wa);
      chk("rnd_ihit", ihit, eh);
      chk("rnd_load", imemload, eh ? res[wa] : 32'h0);
      chk("rnd_iren", iREN, fetching);
      chk("rnd_iaddr", iaddr, fetching ? maddr : 32'h0);
      chk("rnd_hits", hit_count, mh);
      chk("rnd_misses", miss_count, mm);
      if (fetching) begin
        if (!iwait) begin
          vic.delete();
          foreach (res[k]) if (k[5:2] == maddr[5:2]) vic.push_back(k);
          foreach (vic[j]) res.delete(vic[j]);
          res[maddr] = iload;
          fetching = 0;
        end
      end else if (imemREN) begin
        if (eh) mh++;
        else begin
          mm++;
          fetching = 1;
          maddr = wa;
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
